mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter RADIX_BITS, default 2, multiplier bits retired per cycle; legal values 1, 2, 4, and XLEN % RADIX_BITS == 0.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, synchronous and active-high (asserted = 1).
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port opcode  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 SHALL have port op1  input  XLEN  multiplicand.
REQ-009 SHALL have port op2  input  XLEN  multiplier.
REQ-010 SHALL have port kill  input  1  abort the in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  selected product half.

Function
REQ-014 SHALL use FSM states IDLE, BUSY, DONE; N = XLEN/RADIX_BITS.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 SHALL accept a request when in_valid && in_ready && !kill, latching the opcode and the operands, then IDLE->BUSY.
REQ-017 SHALL set the op1 signedness as signed unless opcode==11, and the op2 signedness as signed only for opcode 00/01.
REQ-018 SHALL latch the XLEN-bit unsigned magnitudes of the signedness-extended operands, plus neg = sign1 XOR sign2.
REQ-019 SHALL, in each BUSY cycle, add (op1 magnitude * next RADIX_BITS-digit of op2 magnitude) into a 2*XLEN accumulator, shifted to the digit position, LSB digit first.
REQ-020 SHALL take exactly N BUSY cycles, with a step counter of width $clog2(N)+1.
REQ-021 SHALL, on the last BUSY cycle, register the product (two's-complement-negated if neg) and go BUSY->DONE.
REQ-022 SHALL make out_valid first high in the (N+1)th cycle after the accept cycle.
REQ-023 SHALL set result = product[XLEN-1:0] for opcode 00, else product[2*XLEN-1:XLEN].
REQ-024 SHALL hold result stable while out_valid && !out_ready.
REQ-025 SHALL go DONE->IDLE on out_valid && out_ready; the next request SHALL be accepted no earlier than the following cycle (no same-cycle back-to-back).
REQ-026 SHALL, on kill in BUSY or DONE, return to IDLE next cycle with out_valid = 0 and no result delivered; kill in IDLE SHALL block acceptance that cycle.
REQ-027 SHALL give kill priority over out_ready in DONE.
REQ-028 SHALL produce exact results for all operand combinations, including -2^(XLEN-1) operands.

Reset
REQ-029 SHALL, while rst_b = 1 at a clock edge, enter IDLE with counter, accumulator and neg cleared.
REQ-030 SHALL hold outputs at in_ready = 1, out_valid = 0, result = 0 after reset.
REQ-031 SHALL, on reset mid-operation, discard the operation with no out_valid pulse.
REQ-032 SHALL give reset priority over kill and in_valid.

Configuration
REQ-033 SHALL provide macro MUL_ITER_ZERO_BYPASS_EN.
REQ-034 SHALL, when MUL_ITER_ZERO_BYPASS_EN is defined, go IDLE->DONE directly on accept when op1 == 0 or op2 == 0, with product 0 and out_valid in the cycle after accept.
REQ-035 SHALL, when MUL_ITER_ZERO_BYPASS_EN is undefined, use N BUSY cycles for every operand; results are identical in both cases.

Structure
REQ-036 SHALL place the opcode enum (MUL, MULH, MULHSU, MULHU) and the FSM state enum in shared package mul_pkg.
REQ-037 SHALL implement the partial-product add in sub-module mul_radix_step (inputs: accumulator, op1 magnitude, digit, position; output: next accumulator), combinational, one instance.

Verification
REQ-038 SHALL cover, at XLEN=32, RADIX_BITS=2: MUL 7*6 -> result 0x0000002A, out_valid in the 17th cycle after accept.
REQ-039 SHALL cover MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-040 SHALL cover MULHSU 0xFFFFFFFF(-1)*0xFFFFFFFF(unsigned) -> 0xFFFFFFFF; MUL of the same -> 0x00000001.
REQ-041 SHALL cover out_ready held low 5 cycles in DONE -> result and out_valid stable; in_ready low throughout; release -> IDLE next cycle.
REQ-042 SHALL cover kill at BUSY step 8 -> IDLE next cycle, no out_valid; a following MUL 3*3 -> 0x00000009.
REQ-043 SHALL cover, with MUL_ITER_ZERO_BYPASS_EN, MUL 0*0x1234 -> 0, out_valid 1 cycle after accept; without the macro -> out_valid after 17 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: opcode and FSM state enums plus
// operand-signedness helpers.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // Multiplicand is signed for every opcode except MULHU.
  function automatic logic op1_is_signed(mul_op_e op);
    return op != OP_MULHU;
  endfunction

  // Multiplier is signed only for MUL and MULH.
  function automatic logic op2_is_signed(mul_op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One partial-product step: adds op1 magnitude times a RADIX_BITS-wide digit,
// shifted to the digit position, into the double-width accumulator.
module mul_radix_step #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2,
  parameter int PW         = 5
) (
  input  logic [2*XLEN-1:0]     acc_i,
  input  logic [XLEN-1:0]       mag1_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  input  logic [PW-1:0]         pos_i,
  output logic [2*XLEN-1:0]     acc_o
);

  logic [2*XLEN-1:0] pp;

  always_comb begin
    pp    = {{XLEN{1'b0}}, mag1_i} * {{(2*XLEN-RADIX_BITS){1'b0}}, digit_i};
    acc_o = acc_i + (pp << (int'(pos_i) * RADIX_BITS));
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative RISC-V style multiplier (MUL/MULH/MULHSU/MULHU), RADIX_BITS bits per cycle.
// Optional feature macro: MUL_ITER_ZERO_BYPASS_EN (zero operand skips the BUSY phase).
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      opcode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output mul_state_e      dbg_state
);

  localparam int N  = XLEN / RADIX_BITS;
  localparam int CW = $clog2(N) + 1;

  // Handshake: a transfer occurs on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; result is held
  // until it is taken or the operation is killed. kill/reset win over both.

  mul_state_e            state_q, state_d;
  mul_op_e               op_q, op_d;
  logic [XLEN-1:0]       mag1_q, mag1_d;
  logic [XLEN-1:0]       mag2_q, mag2_d;
  logic                  neg_q, neg_d;
  logic [CW-1:0]         step_q, step_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;

  mul_op_e               op_in;
  logic                  sign1, sign2, accept;
  logic [RADIX_BITS-1:0] digit;
  logic [2*XLEN-1:0]     acc_next;

  assign op_in = mul_op_e'(opcode);
  assign digit = RADIX_BITS'(mag2_q >> (int'(step_q) * RADIX_BITS));

  mul_radix_step #(
    .XLEN       (XLEN),
    .RADIX_BITS (RADIX_BITS),
    .PW         (CW)
  ) u_step (
    .acc_i   (acc_q),
    .mag1_i  (mag1_q),
    .digit_i (digit),
    .pos_i   (step_q),
    .acc_o   (acc_next)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag1_d    = mag1_q;
    mag2_d    = mag2_q;
    neg_d     = neg_q;
    step_d    = step_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    accept    = in_valid && in_ready && !kill;
    sign1     = op1_is_signed(op_in) && op1[XLEN-1];
    sign2     = op2_is_signed(op_in) && op2[XLEN-1];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          mag1_d  = sign1 ? -op1 : op1;
          mag2_d  = sign2 ? -op2 : op2;
          neg_d   = sign1 ^ sign2;
          step_d  = '0;
          acc_d   = '0;
          state_d = ST_BUSY;
`ifdef MUL_ITER_ZERO_BYPASS_EN
          if ((op1 == '0) || (op2 == '0)) begin
            prod_d  = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_BUSY: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = acc_next;
          step_d = step_q + CW'(1);
          if (step_q == CW'(N - 1)) begin
            prod_d  = neg_q ? -acc_next : acc_next;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (kill || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      mag1_q  <= '0;
      mag2_q  <= '0;
      neg_q   <= 1'b0;
      step_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      neg_q   <= neg_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign result    = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter (XLEN=32, RADIX_BITS=2) with a result
// scoreboard; honours MUL_ITER_ZERO_BYPASS_EN for zero-operand latency.
module tb_mul_iter;
  import mul_pkg::*;

  localparam int XLEN       = 32;
  localparam int RADIX_BITS = 2;
  localparam int N          = XLEN / RADIX_BITS;
  localparam int LAT        = N + 1;
`ifdef MUL_ITER_ZERO_BYPASS_EN
  localparam int LAT_ZERO   = 1;
`else
  localparam int LAT_ZERO   = N + 1;
`endif

  logic            clk;
  logic            rst_b;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      opcode;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  mul_state_e      dbg_state;

  int checks;
  int errors;
  logic [XLEN-1:0] exp_q[$];

  mul_iter #(.XLEN(XLEN), .RADIX_BITS(RADIX_BITS)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_mul(logic [1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic signed [2*XLEN+1:0] sa, sb, p;
    sa = (op != 2'b11) ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
    sb = (op <= 2'b01) ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns one cycle after the accept edge (cycle 1).
  task automatic drive_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    opcode   = op;
    op1      = a;
    op2      = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; exp_cyc = cycle index after accept (0 = unchecked).
  task automatic wait_valid(input int exp_cyc);
    int cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: out_valid=%0b required 1 within 200 cycles", out_valid);
    end
    if (exp_cyc != 0) begin
      checks++;
      if (cyc !== exp_cyc) begin
        errors++;
        $display("FAIL latency: out_valid in cycle %0d required %0d", cyc, exp_cyc);
      end
    end
  endtask

  task automatic collect(input string name);
    logic [XLEN-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if (result !== e) begin
      errors++;
      $display("FAIL %s: result=%h required %h", name, result, e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: out_valid=1 seen required 0", name);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_b = 1'b1; in_valid = 1'b1; kill = 1'b1; out_ready = 1'b0;
    opcode = 2'b00; op1 = 32'd5; op2 = 32'd5;
    repeat (3) tick();
    in_valid = 1'b0; kill = 1'b0; rst_b = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b result=%h required 1/0/0", in_ready, out_valid, result);
    end
  endtask

  task automatic test_mul_basic();
    drive_req(2'b00, 32'd7, 32'd6);
    exp_q.push_back(32'h0000002A);
    wait_valid(LAT);
    collect("mul_7x6");
  endtask

  task automatic test_corners();
    logic [1:0]      t_op[9]  = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    logic [XLEN-1:0] t_a[9]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [XLEN-1:0] t_b[9]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    logic [XLEN-1:0] t_e[9]   = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'h00000000,
                                  32'hC0000000, 32'h80000000, 32'h00000000, 32'h00000001};
    for (int i = 0; i < 9; i++) begin
      drive_req(t_op[i], t_a[i], t_b[i]);
      exp_q.push_back(t_e[i]);
      wait_valid(LAT);
      collect("corner");
    end
  endtask

  task automatic test_stall();
    drive_req(2'b11, 32'h12345678, 32'h9ABCDEF0);
    exp_q.push_back(ref_mul(2'b11, 32'h12345678, 32'h9ABCDEF0));
    wait_valid(LAT);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_q[0]) begin
        errors++;
        $display("FAIL stall: out_valid=%0b in_ready=%0b result=%h required 1/0/%h",
                 out_valid, in_ready, result, exp_q[0]);
      end
      tick();
    end
    collect("stall_release");
  endtask

  task automatic test_kill();
    drive_req(2'b00, 32'hDEADBEEF, 32'h00001234);
    repeat (8) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_busy: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    watch_no_valid("kill_busy_quiet", 20);
    drive_req(2'b00, 32'd3, 32'd3);
    exp_q.push_back(32'h00000009);
    wait_valid(LAT);
    collect("mul_after_kill");

    in_valid = 1'b1; kill = 1'b1; opcode = 2'b00; op1 = 32'd5; op2 = 32'd5;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL kill_idle: in_ready=%0b required 1", in_ready);
    end
    watch_no_valid("kill_idle_quiet", 20);

    drive_req(2'b00, 32'd2, 32'd2);
    wait_valid(LAT);
    kill = 1'b1; out_ready = 1'b1;
    tick();
    kill = 1'b0; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_done: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive_req(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (4) tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%0b out_valid=%0b result=%h required 1/0/0", in_ready, out_valid, result);
    end
    watch_no_valid("reset_mid_quiet", 20);
  endtask

  task automatic test_zero();
    drive_req(2'b00, 32'h00000000, 32'h00001234);
    exp_q.push_back(32'h00000000);
    wait_valid(LAT_ZERO);
    collect("zero_mul");
    drive_req(2'b01, 32'hFFFFFFFF, 32'h00000000);
    exp_q.push_back(32'h00000000);
    wait_valid(LAT_ZERO);
    collect("zero_mulh");
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] e;
    drive_req(2'b00, 32'h0000FFFF, 32'h00010001);
    exp_q.push_back(32'hFFFFFFFF);
    wait_valid(LAT);
    e = exp_q.pop_front();
    checks++;
    if (result !== e) begin
      errors++;
      $display("FAIL b2b_first: result=%h required %h", result, e);
    end
    out_ready = 1'b1; in_valid = 1'b1; opcode = 2'b11; op1 = 32'hFFFFFFFF; op2 = 32'h00000010;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_same_cycle: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(32'h0000000F);
    wait_valid(LAT);
    collect("b2b_second");
  endtask

  task automatic test_random();
    logic [1:0]      op;
    logic [XLEN-1:0] v[2];
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0:       v[k] = 32'h80000000;
          1:       v[k] = 32'hFFFFFFFF;
          2:       v[k] = 32'h00000000;
          default: v[k] = $urandom;
        endcase
      end
      drive_req(op, v[0], v[1]);
      exp_q.push_back(ref_mul(op, v[0], v[1]));
      wait_valid(((v[0] == '0) || (v[1] == '0)) ? LAT_ZERO : LAT);
      repeat ($urandom_range(0, 3)) tick();
      collect("random");
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul_basic();
    test_corners();
    test_stall();
    test_kill();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
